// File: rtl/usb_utm_tx.sv
// UTMI full-speed transmit path: SYNC, bit stuffing, NRZI and EOP onto a registered dp/dn pair.
// First K appears two clks after tx_valid is sampled; SIE is paced by a one-clk tx_ready per byte slot.
package usb_utm_tx_pkg;
  typedef logic [7:0] bus8_t;
endpackage

module usb_utm_tx
  import usb_utm_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int STUFF_BITS_N = 6
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  suspend_m,
  input  bus8_t data_in,
  input  logic  tx_valid,
  output logic  tx_ready,
  output logic  dp_tx,
  output logic  dn_tx,
  output logic  tx_oe
);

  localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int OW = $clog2(STUFF_BITS_N + 1);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    EOP_SE0,
    EOP_J
  } state_t;

  state_t        state;
  logic [PW-1:0] phase;
  bus8_t         shreg;
  logic [2:0]    bit_cnt;
  logic [OW-1:0] ones_cnt;
  logic          level;
  logic          stuffed;
  logic          draining;
  logic          eop_cnt;

  logic          bit_strobe;
  logic          sym_start;
  logic          stuff_due;
  logic          raw_bit;
  logic          tx_bit;
  logic          level_nxt;
  logic [PW-1:0] phase_nxt;

  // Symbols launch at phase 0; counters and state advance on the strobe at the end of the bit.
  assign bit_strobe = (phase == PW'(CLKS_PER_BIT - 1));
  assign sym_start  = (phase == '0);
  assign phase_nxt  = bit_strobe ? '0 : phase + PW'(1);
  assign stuff_due  = (ones_cnt == OW'(STUFF_BITS_N));
  assign raw_bit    = (state == SYNC) ? (bit_cnt == 3'd7) : shreg[0];
  assign tx_bit     = stuff_due ? 1'b0 : raw_bit;
  assign level_nxt  = tx_bit ? level : ~level;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      phase    <= '0;
      shreg    <= '0;
      bit_cnt  <= '0;
      ones_cnt <= '0;
      level    <= 1'b1;
      stuffed  <= 1'b0;
      draining <= 1'b0;
      eop_cnt  <= 1'b0;
      tx_ready <= 1'b0;
      tx_oe    <= 1'b0;
      dp_tx    <= 1'b1;
      dn_tx    <= 1'b0;
    end else begin
      tx_ready <= 1'b0;
      case (state)
        IDLE: begin
          phase    <= '0;
          bit_cnt  <= '0;
          ones_cnt <= '0;
          level    <= 1'b1;
          stuffed  <= 1'b0;
          draining <= 1'b0;
          eop_cnt  <= 1'b0;
          tx_oe    <= 1'b0;
          dp_tx    <= 1'b1;
          dn_tx    <= 1'b0;
          if (tx_valid && suspend_m) begin
            state <= SYNC;
          end
        end

        SYNC, DATA: begin
          tx_oe <= 1'b1;
          phase <= phase_nxt;
          if (sym_start) begin
            level    <= level_nxt;
            dp_tx    <= level_nxt;
            dn_tx    <= ~level_nxt;
            ones_cnt <= tx_bit ? ones_cnt + OW'(1) : '0;
            stuffed  <= stuff_due;
          end
          if (bit_strobe) begin
            if (state == SYNC) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                shreg    <= data_in;
                tx_ready <= 1'b1;
                state    <= DATA;
              end
            end else if (stuffed) begin
              // Stuffed bit time: shifter stalls; a trailing stuff ends the packet.
              if (draining) begin
                state <= EOP_SE0;
              end
            end else begin
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (tx_valid) begin
                  shreg    <= data_in;
                  tx_ready <= 1'b1;
                end else if (stuff_due) begin
                  draining <= 1'b1;
                end else begin
                  state <= EOP_SE0;
                end
              end
            end
          end
        end

        EOP_SE0: begin
          tx_oe <= 1'b1;
          phase <= phase_nxt;
          if (sym_start) begin
            dp_tx <= 1'b0;
            dn_tx <= 1'b0;
          end
          if (bit_strobe) begin
            eop_cnt <= 1'b1;
            if (eop_cnt) begin
              state <= EOP_J;
            end
          end
        end

        EOP_J: begin
          tx_oe <= 1'b1;
          phase <= phase_nxt;
          if (sym_start) begin
            dp_tx <= 1'b1;
            dn_tx <= 1'b0;
          end
          if (bit_strobe) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_utm_tx.sv
// Directed bench for usb_utm_tx: expected line symbols and handshake timing are queued per packet
// and checked by an independent monitor sampling on the falling edge.
module tb_usb_utm_tx;

  localparam int CPB = 4;

  logic       clk;
  logic       rst;
  logic       suspend_m;
  logic [7:0] data_in;
  logic       tx_valid;
  logic       tx_ready;
  logic       dp_tx;
  logic       dn_tx;
  logic       tx_oe;

  usb_utm_tx #(.CLKS_PER_BIT(CPB), .STUFF_BITS_N(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .suspend_m (suspend_m),
    .data_in   (data_in),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .dp_tx     (dp_tx),
    .dn_tx     (dn_tx),
    .tx_oe     (tx_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // {dp,dn}: J=2, K=1, SE0=0
  logic [1:0] exp_sym [$];
  int         exp_oe  [$];
  int         exp_rdy [$];
  int         exp_gap [$];
  logic [7:0] pkt [0:3];

  bit mon_en   = 1'b0;
  int pkt_done = 0;
  int cyc      = 0;
  int m_bitc   = 0;
  int m_oe_len = 0;
  int m_rdy_n  = 0;
  int m_last   = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic expect_pkt(input string s, input int oe, input int nrdy, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == "K") exp_sym.push_back(2'b01);
      else if (s[i] == "J") exp_sym.push_back(2'b10);
      else if (s[i] == "0") exp_sym.push_back(2'b00);
    end
    exp_oe.push_back(oe);
    exp_rdy.push_back(nrdy);
    if (nrdy > 1) exp_gap.push_back(gap);
  endtask

  // Monitor: per-cycle symbol check against the queue, packet length and handshake timing.
  always @(negedge clk) begin
    int v;
    cyc++;
    if (!mon_en) begin
      m_bitc = 0; m_oe_len = 0; m_rdy_n = 0;
    end else if (tx_oe) begin
      m_oe_len++;
      if (exp_sym.size() == 0) begin
        chk("sym_extra", int'({dp_tx, dn_tx}), -1);
      end else begin
        chk("sym", int'({dp_tx, dn_tx}), int'(exp_sym[0]));
        m_bitc++;
        if (m_bitc == CPB) begin
          m_bitc = 0;
          void'(exp_sym.pop_front());
        end
      end
      if (tx_ready) begin
        m_rdy_n++;
        if (m_rdy_n == 1) chk("rdy1_pos", m_oe_len, 8 * CPB);
        else if (exp_gap.size() > 0) chk("rdy_gap", cyc - m_last, exp_gap.pop_front());
        else chk("rdy_extra", m_rdy_n, 1);
        m_last = cyc;
      end
    end else begin
      chk("idle_line", int'({dp_tx, dn_tx}), 2);
      chk("idle_rdy", int'(tx_ready), 0);
      if (m_oe_len > 0) begin
        v = (exp_oe.size() > 0) ? exp_oe.pop_front() : -1;
        chk("oe_len", m_oe_len, v);
        v = (exp_rdy.size() > 0) ? exp_rdy.pop_front() : -1;
        chk("rdy_count", m_rdy_n, v);
        chk("bit_align", m_bitc, 0);
        m_bitc = 0; m_oe_len = 0; m_rdy_n = 0;
        pkt_done++;
      end
    end
  end

  task automatic wait_ready(input string name, output bit ok);
    int w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!tx_ready && w < 300);
    ok = tx_ready;
    chk(name, int'(tx_ready), 1);
  endtask

  task automatic send_pkt(input int n, input bit drop_mid);
    int target = pkt_done + 1;
    int w = 0;
    bit ok;
    @(posedge clk); #1;
    data_in = pkt[0]; tx_valid = 1'b1; suspend_m = 1'b1;
    @(posedge clk); #1;
    chk("start_early", int'(tx_oe), 0);
    @(posedge clk); #1;
    chk("start_oe", int'(tx_oe), 1);
    chk("start_k", int'({dp_tx, dn_tx}), 1);
    for (int i = 0; i < n; i++) begin
      wait_ready("ready", ok);
      if (i + 1 < n) data_in = pkt[i + 1];
      else tx_valid = 1'b0;
      if (drop_mid && i == 0 && n > 1) begin
        repeat (10) @(negedge clk);
        tx_valid = 1'b0; suspend_m = 1'b0;
        repeat (8) @(negedge clk);
        tx_valid = 1'b1; suspend_m = 1'b1;
      end
    end
    while (pkt_done < target && w < 600) begin
      @(negedge clk);
      w++;
    end
    chk("pkt_done", int'(pkt_done >= target), 1);
  endtask

  initial begin
    bit ok;
    rst = 1'b0; suspend_m = 1'b1; tx_valid = 1'b0; data_in = 8'h00;
    repeat (3) @(posedge clk); #1;
    chk("rst_oe0", int'(tx_oe), 0);
    chk("rst_dp0", int'(dp_tx), 1);
    chk("rst_dn0", int'(dn_tx), 0);
    chk("rst_rdy0", int'(tx_ready), 0);
    @(negedge clk);
    rst = 1'b1; mon_en = 1'b1;

    // ACK PID, single byte
    expect_pkt("KJKJKJKK JJKJJKKK 00J", 76, 1, 0);
    pkt[0] = 8'hD2;
    send_pkt(1, 1'b0);

    // Two 0xFF: stuffs after data bits 5 and 11
    expect_pkt("KJKJKJKK KKKKK J JJJ JJJ K KKKKK 00J", 116, 2, 36);
    pkt[0] = 8'hFF; pkt[1] = 8'hFF;
    send_pkt(2, 1'b0);

    // Trailing stuff before EOP
    expect_pkt("KJKJKJKK JK KKKKKK J 00J", 80, 1, 0);
    pkt[0] = 8'hFC;
    send_pkt(1, 1'b0);

    // tx_valid and suspend_m dropped mid-byte, restored before the boundary
    expect_pkt("KJKJKJKK KJJKKJJK KKKKJKJK 00J", 108, 2, 32);
    pkt[0] = 8'h55; pkt[1] = 8'h0F;
    send_pkt(2, 1'b1);

    // Reset during the second data byte
    mon_en = 1'b0;
    @(posedge clk); #1;
    data_in = 8'h00; tx_valid = 1'b1;
    wait_ready("rst_rdy1", ok);
    data_in = 8'h00;
    wait_ready("rst_rdy2", ok);
    tx_valid = 1'b0;
    repeat (10) @(posedge clk); #1;
    chk("pre_rst_oe", int'(tx_oe), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_oe", int'(tx_oe), 0);
    chk("arst_line", int'({dp_tx, dn_tx}), 2);
    chk("arst_rdy", int'(tx_ready), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_sym.delete(); exp_oe.delete(); exp_rdy.delete(); exp_gap.delete();
    mon_en = 1'b1;
    expect_pkt("KJKJKJKK JJKJJKKK 00J", 76, 1, 0);
    pkt[0] = 8'hD2;
    send_pkt(1, 1'b0);

    // Suspended: tx_valid held, nothing starts
    @(negedge clk);
    suspend_m = 1'b0; data_in = 8'h3C; tx_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("susp_oe", int'(tx_oe), 0);
      chk("susp_rdy", int'(tx_ready), 0);
    end
    expect_pkt("KJKJKJKK JKKKKKJK 00J", 76, 1, 0);
    pkt[0] = 8'h3C;
    send_pkt(1, 1'b0);

    repeat (4) @(negedge clk);
    chk("sym_left", exp_sym.size(), 0);
    chk("oe_left", exp_oe.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
